// File: rtl/riscv_mc_ctrl_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory ready handshake, run gating, a memory-wait timeout and a retire counter.
module riscv_mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int BRANCH_FULL = 1,
   parameter int RET_CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 cmp_eq,
   input  logic                 cmp_lt,
   input  logic                 cmp_ltu,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 addr_src,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic [1:0]           wb_src,
   output logic                 reg_write,
   output logic                 alu_op,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic                 retired,
   output logic [RET_CNT_W-1:0] retire_count,
   output logic                 halted,
   output logic                 illegal,
   output logic                 timeout
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALU_WB, S_MEM_ADDR,
      S_LOAD, S_LOAD_WB, S_STORE, S_BRANCH, S_JAL, S_JALR_CALC, S_JALR_WB, S_HALT
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             waiting, illegal_hit, timeout_hit;
   logic             br_taken, br_legal;

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = cmp_eq;
         3'b001:  br_taken = !cmp_eq;
         3'b100:  br_taken = cmp_lt;
         3'b101:  br_taken = !cmp_lt;
         3'b110:  br_taken = cmp_ltu;
         3'b111:  br_taken = !cmp_ltu;
         default: br_taken = 1'b0;
      endcase
      br_legal = (funct3[2:1] == 2'b00) || ((BRANCH_FULL != 0) && funct3[2]);
   end

   always_comb begin
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      addr_src    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      wb_src      = 2'b00;
      reg_write   = 1'b0;
      alu_op      = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      retired     = 1'b0;
      halted      = 1'b0;
      waiting     = 1'b0;
      illegal_hit = 1'b0;
      timeout_hit = 1'b0;
      state_next  = state_reg;
      case (state_reg)
         S_FETCH: if (run) begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            waiting   = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            case (opcode)
               OP_R:            state_next = S_EXEC_R;
               OP_I:            state_next = S_EXEC_I;
               OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
               OP_BR: begin
                  state_next  = br_legal ? S_BRANCH : S_HALT;
                  illegal_hit = !br_legal;
               end
               OP_JAL:          state_next = S_JAL;
               OP_JALR:         state_next = S_JALR_CALC;
               OP_LUI:          state_next = S_LUI;
               OP_AUIPC:        state_next = S_AUIPC;
               default: begin
                  state_next  = S_HALT;
                  illegal_hit = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10; alu_src_b = 2'b00; alu_op = 1'b1; state_next = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10; alu_src_b = 2'b10; alu_op = 1'b1; state_next = S_ALU_WB;
         end
         S_LUI: begin
            alu_src_a = 2'b11; alu_src_b = 2'b10; state_next = S_ALU_WB;
         end
         S_AUIPC: begin
            alu_src_a = 2'b01; alu_src_b = 2'b10; state_next = S_ALU_WB;
         end
         S_ALU_WB: begin
            wb_src = 2'b01; reg_write = 1'b1; retired = 1'b1; state_next = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b10;
            state_next = (opcode == OP_LOAD) ? S_LOAD : S_STORE;
         end
         S_LOAD: begin
            addr_src = 1'b1; mem_read = 1'b1; waiting = 1'b1;
            if (mem_ready) state_next = S_LOAD_WB;
         end
         S_LOAD_WB: begin
            wb_src = 2'b00; reg_write = 1'b1; retired = 1'b1; state_next = S_FETCH;
         end
         S_STORE: begin
            addr_src = 1'b1; mem_write = 1'b1; waiting = 1'b1;
            if (mem_ready) begin
               retired    = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_BRANCH: begin
            pc_src = 1'b1; pc_write = br_taken; retired = 1'b1; state_next = S_FETCH;
         end
         S_JALR_CALC: begin
            alu_src_a = 2'b10; alu_src_b = 2'b10; state_next = S_JALR_WB;
         end
         S_JAL, S_JALR_WB: begin
            wb_src = 2'b10; reg_write = 1'b1; pc_src = 1'b1; pc_write = 1'b1;
            retired = 1'b1; state_next = S_FETCH;
         end
         default: halted = 1'b1;
      endcase
      // The request is still visible during the last allowed wait cycle; HALT drops it.
      if ((MEM_TIMEOUT > 0) && waiting && !mem_ready && (wait_cnt_reg == CNT_LIMIT)) begin
         state_next  = S_HALT;
         timeout_hit = 1'b1;
      end
      if (rst) begin
         pc_write = 1'b0; pc_src = 1'b0; addr_src = 1'b0; mem_read = 1'b0;
         mem_write = 1'b0; ir_write = 1'b0; wb_src = 2'b00; reg_write = 1'b0;
         alu_op = 1'b0; alu_src_a = 2'b00; alu_src_b = 2'b00; retired = 1'b0;
         halted = 1'b0; illegal_hit = 1'b0; timeout_hit = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_FETCH;
         wait_cnt_reg <= '0;
         retire_count <= '0;
         illegal      <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (waiting && !mem_ready && (state_next == state_reg))
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
         else
            wait_cnt_reg <= '0;
         if (retired)
            retire_count <= retire_count + RET_CNT_W'(1);
         if (illegal_hit)
            illegal <= 1'b1;
         if (timeout_hit)
            timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_riscv_mc_ctrl_fsm.sv
// Bench for riscv_mc_ctrl_fsm: random instruction streams checked cycle by cycle against
// an instruction-level model of the expected control sequence.
module tb_riscv_mc_ctrl_fsm;
   logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1, run = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0, mem_ready = 1'b0;

   logic pc_write, pc_src, addr_src, mem_read, mem_write, ir_write, reg_write, alu_op;
   logic retired, halted, illegal, timeout;
   logic [1:0] wb_src, alu_src_a, alu_src_b;
   logic [3:0] retire_count;

   logic d2_pc_write, d2_pc_src, d2_addr_src, d2_mem_read, d2_mem_write, d2_ir_write;
   logic d2_reg_write, d2_alu_op, d2_retired, d2_halted, d2_illegal, d2_timeout;
   logic [1:0] d2_wb_src, d2_alu_src_a, d2_alu_src_b;
   logic [7:0] d2_retire_count;

   int checks = 0, errors = 0, exp_ret = 0;

   always #5 clk = ~clk;

   riscv_mc_ctrl_fsm #(.MEM_TIMEOUT(4), .BRANCH_FULL(1), .RET_CNT_W(4)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
      .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .addr_src(addr_src), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .wb_src(wb_src), .reg_write(reg_write),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .retired(retired),
      .retire_count(retire_count), .halted(halted), .illegal(illegal), .timeout(timeout));

   riscv_mc_ctrl_fsm #(.MEM_TIMEOUT(0), .BRANCH_FULL(0), .RET_CNT_W(8)) dut2 (
      .clk(clk), .rst(rst2), .run(run), .opcode(opcode), .funct3(funct3),
      .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu), .mem_ready(mem_ready),
      .pc_write(d2_pc_write), .pc_src(d2_pc_src), .addr_src(d2_addr_src), .mem_read(d2_mem_read),
      .mem_write(d2_mem_write), .ir_write(d2_ir_write), .wb_src(d2_wb_src), .reg_write(d2_reg_write),
      .alu_op(d2_alu_op), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b), .retired(d2_retired),
      .retire_count(d2_retire_count), .halted(d2_halted), .illegal(d2_illegal), .timeout(d2_timeout));

   wire [15:0] outs = {pc_write, pc_src, addr_src, mem_read, mem_write, ir_write, wb_src,
                       reg_write, alu_op, alu_src_a, alu_src_b, retired, halted};
   wire [15:0] outs2 = {d2_pc_write, d2_pc_src, d2_addr_src, d2_mem_read, d2_mem_write, d2_ir_write,
                        d2_wb_src, d2_reg_write, d2_alu_op, d2_alu_src_a, d2_alu_src_b,
                        d2_retired, d2_halted};

   function automatic logic [15:0] ov(input logic pcw, pcs, as, mr, mw, irw,
                                      input logic [1:0] wb, input logic rw, aop,
                                      input logic [1:0] sa, sb, input logic ret, hl);
      return {pcw, pcs, as, mr, mw, irw, wb, rw, aop, sa, sb, ret, hl};
   endfunction

   localparam logic [15:0] V_F   = {3'b000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
   localparam logic [15:0] V_FR  = {3'b100, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
   localparam logic [15:0] V_H   = 16'h0001;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic mr, input logic [15:0] exp, input bit sel2 = 0);
      mem_ready = mr;
      @(negedge clk);
      chk(tag, sel2 ? {16'h0, outs2} : {16'h0, outs}, {16'h0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("rst_outs", {16'h0, outs}, 32'h0);
      chk("rst_count", {28'h0, retire_count}, 32'h0);
      chk("rst_flags", {30'h0, illegal, timeout}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_ret = 0;
   endtask

   // Instruction-level model: the expected cycle sequence is built from the instruction class.
   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic eq, lt, ltu,
                            input int idle, input int fw, input int mw, output bit hlt);
      bit exp_ill, legal, taken;
      opcode = opc; funct3 = f3; cmp_eq = eq; cmp_lt = lt; cmp_ltu = ltu;
      hlt = 0; exp_ill = 0;
      run = 1'b0;
      repeat (idle) step("idle", 1'($urandom), 16'h0);
      run = 1'b1;
      for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, V_F);
      step("fetch", 1'b1, V_FR);
      run = 1'($urandom);
      step("decode", 1'($urandom), ov(0,0,0,0,0,0,2'd0,0,0,2'd1,2'd2,0,0));
      case (opc)
         7'b0110011: step("exec_r", 1'($urandom), ov(0,0,0,0,0,0,2'd0,0,1,2'd2,2'd0,0,0));
         7'b0010011: step("exec_i", 1'($urandom), ov(0,0,0,0,0,0,2'd0,0,1,2'd2,2'd2,0,0));
         7'b0110111: step("lui",    1'($urandom), ov(0,0,0,0,0,0,2'd0,0,0,2'd3,2'd2,0,0));
         7'b0010111: step("auipc",  1'($urandom), ov(0,0,0,0,0,0,2'd0,0,0,2'd1,2'd2,0,0));
         7'b0000011, 7'b0100011: begin
            step("mem_addr", 1'($urandom), ov(0,0,0,0,0,0,2'd0,0,0,2'd2,2'd2,0,0));
            if (opc == 7'b0000011) begin
               for (int i = 0; i < mw; i++) step("load_wait", 1'b0, ov(0,0,1,1,0,0,2'd0,0,0,2'd0,2'd0,0,0));
               step("load", 1'b1, ov(0,0,1,1,0,0,2'd0,0,0,2'd0,2'd0,0,0));
               step("load_wb", 1'($urandom), ov(0,0,0,0,0,0,2'd0,1,0,2'd0,2'd0,1,0));
            end else begin
               for (int i = 0; i < mw; i++) step("store_wait", 1'b0, ov(0,0,1,0,1,0,2'd0,0,0,2'd0,2'd0,0,0));
               step("store", 1'b1, ov(0,0,1,0,1,0,2'd0,0,0,2'd0,2'd0,1,0));
            end
            exp_ret++;
         end
         7'b1100011: begin
            legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 >= 3'd4);
            case (f3)
               3'd0: taken = eq;   3'd1: taken = !eq;
               3'd4: taken = lt;   3'd5: taken = !lt;
               3'd6: taken = ltu;  3'd7: taken = !ltu;
               default: taken = 0;
            endcase
            if (legal) begin
               step("branch", 1'($urandom), ov(taken,1,0,0,0,0,2'd0,0,0,2'd0,2'd0,1,0));
               exp_ret++;
            end else begin
               hlt = 1; exp_ill = 1;
            end
         end
         7'b1101111: begin
            step("jal", 1'($urandom), ov(1,1,0,0,0,0,2'd2,1,0,2'd0,2'd0,1,0));
            exp_ret++;
         end
         7'b1100111: begin
            step("jalr_calc", 1'($urandom), ov(0,0,0,0,0,0,2'd0,0,0,2'd2,2'd2,0,0));
            step("jalr_wb", 1'($urandom), ov(1,1,0,0,0,0,2'd2,1,0,2'd0,2'd0,1,0));
            exp_ret++;
         end
         default: begin
            hlt = 1; exp_ill = 1;
         end
      endcase
      if (opc inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111}) begin
         step("alu_wb", 1'($urandom), ov(0,0,0,0,0,0,2'd1,1,0,2'd0,2'd0,1,0));
         exp_ret++;
      end
      if (hlt) begin
         run = 1'b1;
         step("halt", 1'b1, V_H);
         step("halt_hold", 1'($urandom), V_H);
      end
      chk("illegal", {31'h0, illegal}, {31'h0, exp_ill});
      chk("timeout", {31'h0, timeout}, 32'h0);
      chk("retire_count", {28'h0, retire_count}, 32'(exp_ret % 16));
   endtask

   logic [6:0] op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

   initial begin
      bit hlt;
      run = 1'b1; mem_ready = 1'b1;
      #2;
      chk("init_outs", {16'h0, outs}, 32'h0);
      chk("init_count", {28'h0, retire_count}, 32'h0);
      chk("init_flags", {30'h0, illegal, timeout}, 32'h0);
      @(posedge clk); #1;
      do_reset();

      // ADDI x1,x0,5 with single-cycle memory
      run_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 0, 0, hlt);
      chk("addi_count", {28'h0, retire_count}, 32'd1);
      // LW with three not-ready cycles in LOAD
      run_instr(7'b0000011, 3'b010, 0, 0, 0, 1, 0, 3, hlt);
      // BLT taken / not taken
      run_instr(7'b1100011, 3'b100, 0, 1, 0, 0, 0, 0, hlt);
      run_instr(7'b1100011, 3'b100, 0, 0, 0, 0, 1, 0, hlt);
      // JAL then JALR
      run_instr(7'b1101111, 3'b000, 0, 0, 0, 0, 0, 0, hlt);
      run_instr(7'b1100111, 3'b000, 0, 0, 0, 0, 2, 0, hlt);
      // Unknown opcode
      run_instr(7'h7F, 3'b000, 0, 0, 0, 0, 0, 0, hlt);
      chk("op7f_halted", {31'h0, halted}, 32'd1);
      do_reset();

      // Fetch timeout with MEM_TIMEOUT=4: four request cycles, then HALT until reset
      run = 1'b1; opcode = 7'b0010011;
      repeat (4) step("to_fetch_req", 1'b0, V_F);
      repeat (3) step("to_halt", 1'b1, V_H);
      chk("to_timeout", {31'h0, timeout}, 32'd1);
      chk("to_illegal", {31'h0, illegal}, 32'd0);
      do_reset();

      // Retire counter wrap (4-bit)
      repeat (17) run_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 0, 0, hlt);
      chk("wrap_count", {28'h0, retire_count}, 32'd1);

      // Randomised instruction stream
      for (int n = 0; n < 80; n++) begin
         int k;
         k = ($urandom_range(0, 11) == 0) ? 9 : int'($urandom_range(0, 8));
         run_instr(op_tab[k], 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), hlt);
         if (hlt) do_reset();
      end

      // Reset in the middle of a STORE wait
      run_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 0, 0, hlt);
      run = 1'b1; opcode = 7'b0100011;
      step("st_fetch", 1'b1, V_FR);
      step("st_decode", 1'b1, ov(0,0,0,0,0,0,2'd0,0,0,2'd1,2'd2,0,0));
      step("st_addr", 1'b1, ov(0,0,0,0,0,0,2'd0,0,0,2'd2,2'd2,0,0));
      step("st_wait", 1'b0, ov(0,0,1,0,1,0,2'd0,0,0,2'd0,2'd0,0,0));
      mem_ready = 1'b0;
      #2;
      chk("st_pre_rst", {31'h0, mem_write}, 32'd1);
      rst = 1'b1;
      #1;
      chk("st_rst_memwr", {31'h0, mem_write}, 32'd0);
      chk("st_rst_outs", {16'h0, outs}, 32'h0);
      chk("st_rst_count", {28'h0, retire_count}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ret = 0;
      step("st_restart_fetch", 1'b1, V_FR);

      // Second instance: BRANCH_FULL=0, MEM_TIMEOUT=0
      rst = 1'b1;
      rst2 = 1'b0;
      run = 1'b1; opcode = 7'b1100011; funct3 = 3'b100; cmp_lt = 1'b1;
      repeat (20) step("nt_fetch_wait", 1'b0, V_F, 1);
      step("nt_fetch", 1'b1, V_FR, 1);
      step("nt_decode", 1'b1, ov(0,0,0,0,0,0,2'd0,0,0,2'd1,2'd2,0,0), 1);
      step("nt_halt", 1'b1, V_H, 1);
      chk("nt_illegal", {31'h0, d2_illegal}, 32'd1);
      chk("nt_timeout", {31'h0, d2_timeout}, 32'd0);
      chk("nt_count", {24'h0, d2_retire_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
